// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared RV32I opcode constants, hazard FSM states and operand-usage decode helpers.
// Pure declarations: no latency, no flow control.
package hazard_stall_ctrl_pkg;

  localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
  localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
  localparam logic [6:0] OPCODE_OP     = 7'b0110011;
  localparam logic [6:0] OPCODE_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
  localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
  localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
  localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
  localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;

  typedef enum logic [2:0] {
    RUN      = 3'd0,
    MEM_WAIT = 3'd1,
    DRAIN    = 3'd2,
    HALTED   = 3'd3,
    ERROR    = 3'd4
  } hazard_state_e;

  function automatic logic uses_rs1(input logic [6:0] op);
    return op inside {OPCODE_OP, OPCODE_OPIMM, OPCODE_LOAD,
                      OPCODE_STORE, OPCODE_BRANCH, OPCODE_JALR};
  endfunction

  function automatic logic uses_rs2(input logic [6:0] op);
    return op inside {OPCODE_OP, OPCODE_STORE, OPCODE_BRANCH};
  endfunction

endpackage

// File: rtl/hazard_perf_counter.sv
// Single saturating event counter; counts one per cycle with inc high, holds at all-ones.
// Latency: value visible the cycle after the event; no backpressure.
module hazard_perf_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (inc && (cnt != {CNT_W{1'b1}})) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline stall/flush/bubble sequencer for the 5-stage core; controls are same-cycle combinational.
// Backpressure: dmem waits freeze the pipe; HAZARD_PERF_CNT_EN adds saturating perf counters.
module hazard_stall_ctrl
  import hazard_stall_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT  = 255,
  parameter int DRAIN_CYCLES = 4,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       if_id_opcode,
  input  logic [4:0]       if_id_rs1,
  input  logic [4:0]       if_id_rs2,
  input  logic [6:0]       id_ex_opcode,
  input  logic [4:0]       id_ex_dest,
  input  logic             ex_branch_taken,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  input  logic             halt_req,
  output logic             pc_stall,
  output logic             if_id_stall,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_stall,
  output logic             mem_wb_bubble,
  output logic             halt_ack,
  output logic             mem_timeout_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] freeze_cnt
);

  localparam int WAIT_W  = $clog2(MEM_TIMEOUT + 1);
  localparam int DRAIN_W = $clog2(DRAIN_CYCLES + 1);

  hazard_state_e       state;
  hazard_state_e       ret_state;
  logic [WAIT_W-1:0]   wait_cnt;
  logic [DRAIN_W-1:0]  drain_cnt;

  logic load_use;
  logic mem_wait;
  logic freeze;
  logic lu_win;

  assign load_use = (id_ex_opcode == OPCODE_LOAD) && (id_ex_dest != 5'd0) &&
                    ((uses_rs1(if_id_opcode) && (if_id_rs1 == id_ex_dest)) ||
                     (uses_rs2(if_id_opcode) && (if_id_rs2 == id_ex_dest)));
  assign mem_wait = dmem_req && !dmem_ready;
  assign freeze   = mem_wait || (state == ERROR) || (state == HALTED);
  // A redirect squashes the decode instruction, so its load-use is moot.
  assign lu_win   = !freeze && !ex_branch_taken && load_use;

  always_comb begin
    pc_stall      = 1'b0;
    if_id_stall   = 1'b0;
    if_id_flush   = 1'b0;
    id_ex_flush   = 1'b0;
    ex_mem_stall  = 1'b0;
    mem_wb_bubble = 1'b0;
    if (freeze) begin
      pc_stall      = 1'b1;
      if_id_stall   = 1'b1;
      ex_mem_stall  = 1'b1;
      mem_wb_bubble = 1'b1;
    end else if (ex_branch_taken) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (load_use) begin
      pc_stall    = 1'b1;
      if_id_stall = 1'b1;
      id_ex_flush = 1'b1;
    end else if ((state == DRAIN) && halt_req) begin
      // Dropping halt_req leaves DRAIN without discarding this cycle's fetch.
      pc_stall    = 1'b1;
      if_id_flush = 1'b1;
    end
  end

  assign halt_ack        = (state == HALTED);
  assign mem_timeout_err = (state == ERROR);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= RUN;
      ret_state <= RUN;
      wait_cnt  <= '0;
      drain_cnt <= DRAIN_W'(DRAIN_CYCLES);
    end else begin
      case (state)
        RUN: begin
          if (mem_wait) begin
            state     <= MEM_WAIT;
            ret_state <= RUN;
            wait_cnt  <= WAIT_W'(1);
          end else if (halt_req) begin
            state     <= DRAIN;
            drain_cnt <= DRAIN_W'(DRAIN_CYCLES);
          end
        end
        MEM_WAIT: begin
          if (!mem_wait) begin
            state    <= ret_state;
            wait_cnt <= '0;
          end else if (wait_cnt == WAIT_W'(MEM_TIMEOUT)) begin
            state <= ERROR;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        DRAIN: begin
          if (mem_wait) begin
            state    <= MEM_WAIT;
            wait_cnt <= WAIT_W'(1);
            if (halt_req) ret_state <= DRAIN;
            else          ret_state <= RUN;
          end else if (!halt_req) begin
            state <= RUN;
          end else if (drain_cnt == '0) begin
            state <= HALTED;
          end else if (!lu_win) begin
            drain_cnt <= drain_cnt - 1'b1;
            if (drain_cnt == DRAIN_W'(1)) state <= HALTED;
          end
        end
        HALTED: begin
          if (!halt_req) state <= RUN;
        end
        ERROR: begin
          state <= ERROR;
        end
        default: begin
          state <= RUN;
        end
      endcase
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  hazard_perf_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (lu_win),
    .cnt   (stall_cnt)
  );

  hazard_perf_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (!freeze && ex_branch_taken),
    .cnt   (flush_cnt)
  );

  hazard_perf_counter #(.CNT_W(CNT_W)) u_freeze_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (mem_wait),
    .cnt   (freeze_cnt)
  );
`else
  assign stall_cnt  = '0;
  assign flush_cnt  = '0;
  assign freeze_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl: stimulus pushes expected controls, a negedge monitor pops and checks.
module tb_hazard_stall_ctrl;

  localparam logic [6:0] OP_LOAD  = 7'h03;
  localparam logic [6:0] OP_STORE = 7'h23;
  localparam logic [6:0] OP_OP    = 7'h33;
  localparam logic [6:0] OP_OPIMM = 7'h13;

  // {pc_stall, if_id_stall, if_id_flush, id_ex_flush, ex_mem_stall, mem_wb_bubble, halt_ack, mem_timeout_err}
  localparam logic [7:0] NONE = 8'b0000_0000;
  localparam logic [7:0] LU   = 8'b1101_0000;
  localparam logic [7:0] BR   = 8'b0011_0000;
  localparam logic [7:0] FRZ  = 8'b1100_1100;
  localparam logic [7:0] DRN  = 8'b1010_0000;
  localparam logic [7:0] HLT  = 8'b1100_1110;
  localparam logic [7:0] ERR  = 8'b1100_1101;

`ifdef HAZARD_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic [6:0]  if_id_opcode;
  logic [4:0]  if_id_rs1;
  logic [4:0]  if_id_rs2;
  logic [6:0]  id_ex_opcode;
  logic [4:0]  id_ex_dest;
  logic        ex_branch_taken;
  logic        dmem_req;
  logic        dmem_ready;
  logic        halt_req;
  logic        pc_stall, if_id_stall, if_id_flush, id_ex_flush;
  logic        ex_mem_stall, mem_wb_bubble, halt_ack, mem_timeout_err;
  logic [31:0] stall_cnt, flush_cnt, freeze_cnt;

  hazard_stall_ctrl #(.MEM_TIMEOUT(8), .DRAIN_CYCLES(4), .CNT_W(32)) dut (
    .clk             (clk),
    .reset           (reset),
    .if_id_opcode    (if_id_opcode),
    .if_id_rs1       (if_id_rs1),
    .if_id_rs2       (if_id_rs2),
    .id_ex_opcode    (id_ex_opcode),
    .id_ex_dest      (id_ex_dest),
    .ex_branch_taken (ex_branch_taken),
    .dmem_req        (dmem_req),
    .dmem_ready      (dmem_ready),
    .halt_req        (halt_req),
    .pc_stall        (pc_stall),
    .if_id_stall     (if_id_stall),
    .if_id_flush     (if_id_flush),
    .id_ex_flush     (id_ex_flush),
    .ex_mem_stall    (ex_mem_stall),
    .mem_wb_bubble   (mem_wb_bubble),
    .halt_ack        (halt_ack),
    .mem_timeout_err (mem_timeout_err),
    .stall_cnt       (stall_cnt),
    .flush_cnt       (flush_cnt),
    .freeze_cnt      (freeze_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [7:0]  ctl;
    logic [7:0]  msk;
    bit          chk_cnt;
    int unsigned st;
    int unsigned fl;
    int unsigned fz;
  } exp_t;

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;

  task automatic step(input string nm, input logic [7:0] ctl, input logic [7:0] msk,
                      input bit chk, input int unsigned st, input int unsigned fl,
                      input int unsigned fz);
    exp_t e;
    e.name = nm; e.ctl = ctl; e.msk = msk; e.chk_cnt = chk;
    e.st = st; e.fl = fl; e.fz = fz;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input string nm, input logic [7:0] ctl);
    step(nm, ctl, 8'hFF, 1'b0, 0, 0, 0);
  endtask

  task automatic cyc_cnt(input string nm, input logic [7:0] ctl,
                         input int unsigned st, input int unsigned fl, input int unsigned fz);
    step(nm, ctl, 8'hFF, 1'b1, st, fl, fz);
  endtask

  task automatic clr();
    if_id_opcode = '0; if_id_rs1 = '0; if_id_rs2 = '0;
    id_ex_opcode = '0; id_ex_dest = '0;
    ex_branch_taken = 1'b0; dmem_req = 1'b0; dmem_ready = 1'b0;
  endtask

  task automatic set_lu(input logic [4:0] dest, input logic [6:0] dop,
                        input logic [4:0] r1, input logic [4:0] r2);
    id_ex_opcode = OP_LOAD; id_ex_dest = dest;
    if_id_opcode = dop; if_id_rs1 = r1; if_id_rs2 = r2;
  endtask

  // Monitor: one expectation is consumed at each falling edge.
  initial begin
    exp_t        e;
    logic [7:0]  act;
    logic [31:0] want;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e   = sb_q.pop_front();
        act = {pc_stall, if_id_stall, if_id_flush, id_ex_flush,
               ex_mem_stall, mem_wb_bubble, halt_ack, mem_timeout_err};
        checks++;
        if ((act & e.msk) != (e.ctl & e.msk)) begin
          errors++;
          $display("FAIL %s: ctl got %b want %b (mask %b)", e.name, act, e.ctl, e.msk);
        end
        if (e.chk_cnt) begin
          want = PERF ? 32'(e.st) : 32'd0;
          checks++;
          if (stall_cnt != want) begin
            errors++;
            $display("FAIL %s.stall_cnt: got %0d want %0d", e.name, stall_cnt, want);
          end
          want = PERF ? 32'(e.fl) : 32'd0;
          checks++;
          if (flush_cnt != want) begin
            errors++;
            $display("FAIL %s.flush_cnt: got %0d want %0d", e.name, flush_cnt, want);
          end
          want = PERF ? 32'(e.fz) : 32'd0;
          checks++;
          if (freeze_cnt != want) begin
            errors++;
            $display("FAIL %s.freeze_cnt: got %0d want %0d", e.name, freeze_cnt, want);
          end
        end
      end
    end
  end

  initial begin
    reset = 1'b0;
    halt_req = 1'b0;
    clr();
    @(posedge clk);
    #1;
    cyc_cnt("reset_state", NONE, 0, 0, 0);
    reset = 1'b1;

    // Load-use detection and its exclusions
    set_lu(5'd5, OP_OP, 5'd5, 5'd7);     cyc("lu_rs1", LU);
    clr();                               cyc("lu_after", NONE);
    set_lu(5'd0, OP_OP, 5'd0, 5'd0);     cyc("lu_x0", NONE);
    set_lu(5'd9, OP_STORE, 5'd2, 5'd9);  cyc("lu_rs2", LU);
    set_lu(5'd9, OP_OPIMM, 5'd3, 5'd9);  cyc("lu_opimm_rs2", NONE);
    set_lu(5'd5, OP_OP, 5'd5, 5'd7);
    ex_branch_taken = 1'b1;              cyc("lu_with_branch", BR);
    clr();                               cyc_cnt("lu_branch_after", NONE, 2, 1, 0);

    // Three-cycle memory freeze with a branch held in EX
    dmem_req = 1'b1; ex_branch_taken = 1'b1;
    for (int i = 0; i < 3; i++) cyc($sformatf("freeze_%0d", i), FRZ);
    dmem_ready = 1'b1;                   cyc("freeze_release_branch", BR);
    clr();                               cyc_cnt("freeze_after", NONE, 2, 2, 3);

    // Clean halt: four drain cycles
    halt_req = 1'b1;                     cyc("halt_req", NONE);
    for (int i = 0; i < 4; i++) cyc($sformatf("drain_%0d", i), DRN);
    cyc("halted", HLT);
    cyc("halted_hold", HLT);
    halt_req = 1'b0;                     cyc("halt_drop", HLT);
    cyc("resume", NONE);

    // Halt with a load-use in the middle: five drain cycles
    halt_req = 1'b1;                     cyc("halt2_req", NONE);
    cyc("drain2_0", DRN);
    set_lu(5'd3, OP_OP, 5'd1, 5'd3);     cyc("drain2_load_use", LU);
    clr();
    for (int i = 1; i < 4; i++) cyc($sformatf("drain2_%0d", i), DRN);
    cyc("halted2", HLT);
    halt_req = 1'b0;                     cyc("halt2_drop", HLT);
    cyc_cnt("resume2", NONE, 3, 2, 3);

    // halt_req withdrawn mid-drain
    halt_req = 1'b1;                     cyc("halt3_req", NONE);
    cyc("drain3_0", DRN);
    halt_req = 1'b0;                     cyc("drain3_drop", NONE);
    cyc("drain3_run", NONE);

    // Asynchronous reset while draining
    halt_req = 1'b1;                     cyc("halt4_req", NONE);
    cyc("drain4_0", DRN);
    cyc("drain4_1", DRN);
    reset = 1'b0;                        cyc_cnt("reset_in_drain", NONE, 0, 0, 0);
    reset = 1'b1;                        cyc("reset_release_run", NONE);
    cyc("post_reset_drain", DRN);
    halt_req = 1'b0;                     cyc("post_reset_drop", NONE);

    // Memory timeout at MEM_TIMEOUT=8
    dmem_req = 1'b1; dmem_ready = 1'b0;
    for (int i = 1; i <= 7; i++) cyc($sformatf("wait_%0d", i), FRZ);
    step("wait_8", FRZ, 8'hFE, 1'b0, 0, 0, 0);
    step("wait_9", FRZ, 8'hFE, 1'b0, 0, 0, 0);
    cyc("timeout_err", ERR);
    clr();                               cyc("err_sticky", ERR);
    cyc("err_sticky2", ERR);
    reset = 1'b0;                        cyc_cnt("err_async_reset", NONE, 0, 0, 0);
    reset = 1'b1;                        cyc("err_cleared", NONE);

    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d expectations left, want 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
